// File: rtl/pwm_output_stage.sv
// pwm_output_stage: drives 16 chip outputs as forced-low, constant-high or a shared
// 8-bit PWM waveform whose duty is double-buffered to the period boundary.
module pwm_output_stage #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       duty_q, duty_d;
  logic [15:0]      out_q, out_d;
  logic             period_start_q, period_start_d;

  logic             tick_c;
  logic             period_end_c;
  logic             pwm_c;
  logic [15:0]      en_c;
  logic [15:0]      pwm_en_c;

  // Next-state: prescaler, period counter, duty shadow and per-bit output select
  always_comb begin
    tick_c         = (pre_q == PRE_MAX);
    period_end_c   = tick_c && (cnt_q == 8'hFF);
    pre_d          = tick_c ? '0 : pre_q + PRE_W'(1);
    cnt_d          = tick_c ? cnt_q + 8'd1 : cnt_q;
    duty_d         = period_end_c ? pwm_duty_cycle : duty_q;
    pwm_c          = (duty_q == 8'hFF) || (cnt_q < duty_q);
    en_c           = {en_reg_out_15_8, en_reg_out_7_0};
    pwm_en_c       = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    out_d          = en_c & (~pwm_en_c | {16{pwm_c}});
    // Pulse lands on the cycle where cnt==0 and pre==0 after a wrap, never right after reset
    period_start_d = period_end_c;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q          <= '0;
      cnt_q          <= 8'h00;
      duty_q         <= 8'h00;
      out_q          <= 16'h0000;
      period_start_q <= 1'b0;
    end else begin
      pre_q          <= pre_d;
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed bench for pwm_output_stage with CLK_DIV=13.
module tb_pwm_output_stage;

  localparam int unsigned CLK_DIV = 13;
  localparam int          PERIOD  = 256 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] e;
  logic [15:0] p;
  logic [7:0]  duty;
  logic [15:0] out;
  logic        period_start;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [15:0] e;
    logic [15:0] p;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  pwm_output_stage #(.CLK_DIV(CLK_DIV)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (e[7:0]),
    .en_reg_out_15_8 (e[15:8]),
    .en_reg_pwm_7_0  (p[7:0]),
    .en_reg_pwm_15_8 (p[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts on a period_start cycle; checks every out sample of one period against the
  // model and ends on the next period_start cycle. Optional duty write at index wr_at.
  task automatic measure(input string name, input int exp_high, input int wr_at,
                         input logic [7:0] wr_val);
    int          len;
    int          errs;
    logic        pwm;
    logic [15:0] expv;
    len  = 0;
    errs = 0;
    for (int i = 1; i <= PERIOD + 600; i++) begin
      step();
      len  = i;
      pwm  = ((i - 1) < exp_high);
      expv = e & (~p | {16{pwm}});
      if (out !== expv) errs++;
      if (i == wr_at) duty = wr_val;
      if (period_start) break;
    end
    chk({name, " period_len"}, 32'(len), 32'(PERIOD));
    chk({name, " out_errs"}, 32'(errs), 32'd0);
  endtask

  initial begin
    int n;
    vecs[0] = '{"en0_static",  16'h0001, 16'h0000, 16'h0001};
    vecs[1] = '{"all_off",     16'h0000, 16'hFFFF, 16'h0000};
    vecs[2] = '{"all_high",    16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[3] = '{"pwm_duty0",   16'hFFFF, 16'hFFFF, 16'h0000};
    vecs[4] = '{"mix_a",       16'hF0F0, 16'h00FF, 16'hF000};
    vecs[5] = '{"mix_b",       16'h1234, 16'h0204, 16'h1030};

    rst_n = 1'b0;
    e     = 16'h0000;
    p     = 16'h0000;
    duty  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", 32'(out), 32'h0);
    chk("reset_ps", 32'(period_start), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Static drive during the first period (duty_q still 0)
    for (int k = 0; k < 6; k++) begin
      e = vecs[k].e;
      p = vecs[k].p;
      step();
      chk(vecs[k].name, 32'(out), 32'(vecs[k].exp));
    end

    // Asynchronous reset mid-run with outputs high
    e    = 16'hFFFF;
    p    = 16'h0000;
    duty = 8'h5A;
    step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(out), 32'h0);
    chk("async_rst_ps", 32'(period_start), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    e    = 16'h0001;
    p    = 16'h0001;
    duty = 8'h80;

    n = 0;
    for (int i = 1; i <= 5000; i++) begin
      step();
      n = i;
      if (period_start) break;
    end
    chk("first_period_start", 32'(n), 32'(PERIOD));

    // 50% PWM, repeating
    measure("duty80_a", 1664, -1, 8'h00);
    duty = 8'h00;
    measure("duty80_b", 1664, -1, 8'h00);

    // Extremes
    measure("duty00_1", 0, -1, 8'h00);
    measure("duty00_2", 0, -1, 8'h00);
    duty = 8'hFF;
    measure("duty00_3", 0, -1, 8'h00);
    measure("dutyFF_1", PERIOD, -1, 8'h00);
    measure("dutyFF_2", PERIOD, -1, 8'h00);
    duty = 8'h01;
    measure("dutyFF_3", PERIOD, -1, 8'h00);
    duty = 8'h40;
    measure("duty01", 13, -1, 8'h00);

    // Glitch-free update: write 0xC0 at cnt=0x10 during a 0x40 period
    measure("duty40_midwrite", 832, 16 * CLK_DIV, 8'hC0);
    e    = 16'hFFFF;
    p    = 16'hAAAA;
    duty = 8'h80;
    measure("dutyC0_mixed", 2496, -1, 8'h00);

    // Mixed bits: even bits constant 1, odd bits PWM at 50%
    measure("mixed_duty80", 1664, -1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
